divisor_issuer: RTL and testbench

Request issuer and result collector for the divider core (`divisor_top` / `divisor_segmentado_top`). It accepts operand pairs on a valid/ready stream and drives the divider's START/NUMERADOR/DENOMINADOR side. It captures COC/RES on each DONE pulse and returns results in issue order on a valid/ready output stream. Credit-based flow control ensures no DONE result is ever lost.

---
 rtl/divisor_pkg.sv | 5 +
 rtl/divisor_fifo.sv | 46 ++++
 rtl/divisor_issuer.sv | 115 +++++++++++
 tb/tb_divisor_issuer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// divisor_pkg: constants shared by the divider request issuer and its FIFOs.
package divisor_pkg;
  localparam logic DIV0_COC_BIT = 1'b1;
  localparam logic DIV0_RES_BIT = 1'b0;
endpackage

// File: rtl/divisor_fifo.sv
// divisor_fifo: synchronous first-word-fall-through FIFO with occupancy count.
module divisor_fifo
  import divisor_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = r_count == CW'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/divisor_issuer.sv
// divisor_issuer: issues operand pairs to the divider and returns results in order,
// with credit flow control so every DONE always has a free result slot.
module divisor_issuer
  import divisor_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int DEPTH     = 4,
  parameter bit PIPELINED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_num,
  input  logic [SIZE-1:0] in_den,
  output logic            div_start,
  output logic [SIZE-1:0] div_num,
  output logic [SIZE-1:0] div_den,
  input  logic            div_done,
  input  logic [SIZE-1:0] div_coc,
  input  logic [SIZE-1:0] div_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_coc,
  output logic [SIZE-1:0] out_res,
  output logic            out_div0,
  output logic            busy,
  output logic            err_unexpected
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  typedef struct packed {
    logic [SIZE-1:0] coc;
    logic [SIZE-1:0] res;
    logic            div0;
  } divisor_result_t;
  logic [CW-1:0]   r_out;
  logic            r_start;
  logic [SIZE-1:0] r_num;
  logic [SIZE-1:0] r_den;
  logic            r_err;
  logic            w_acc;
  logic            w_done;
  logic            w_pop;
  logic            w_flag;
  logic            w_ffull;
  logic            w_fempty;
  logic [CW-1:0]   w_fcount;
  logic            w_rpush;
  logic            w_rfull;
  logic            w_rempty;
  logic [CW-1:0]   w_rcount;
  logic [CW:0]     w_used;
  logic            w_unused_fifo;
  divisor_result_t w_rdin;
  divisor_result_t w_head;
  assign w_used   = {1'b0, r_out} + {1'b0, w_rcount};
  // credits = DEPTH - outstanding - buffered; non-pipelined dividers also need a fully idle issuer
  assign in_ready = !rst && (w_used < LIM) && (PIPELINED || (r_out == '0 && w_rcount == '0));
  assign w_acc    = in_valid && in_ready;
  assign w_done   = div_done && r_out != '0;
  assign w_rpush  = w_done;
  assign w_pop    = out_valid && out_ready;
  assign w_rdin   = w_flag ? {{SIZE{DIV0_COC_BIT}}, {SIZE{DIV0_RES_BIT}}, 1'b1}
                           : {div_coc, div_res, 1'b0};
  assign w_unused_fifo = ^{w_ffull, w_fempty, w_fcount, w_rfull};
  divisor_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_flag (
    .clk   (clk),
    .rst   (rst),
    .push  (w_acc),
    .pop   (w_done),
    .din   (in_den == '0),
    .dout  (w_flag),
    .full  (w_ffull),
    .empty (w_fempty),
    .count (w_fcount)
  );
  divisor_fifo #(.WIDTH($bits(divisor_result_t)), .DEPTH(DEPTH)) u_res (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rpush),
    .pop   (w_pop),
    .din   (w_rdin),
    .dout  (w_head),
    .full  (w_rfull),
    .empty (w_rempty),
    .count (w_rcount)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_start <= 1'b0;
      r_num   <= '0;
      r_den   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_start <= w_acc;
      if (w_acc) begin
        r_num <= in_num;
        r_den <= in_den;
      end
      r_out <= r_out + CW'(w_acc) - CW'(w_done);
      if (div_done && r_out == '0) r_err <= 1'b1;
    end
  end
  assign div_start      = r_start;
  assign div_num        = r_num;
  assign div_den        = r_den;
  assign out_valid      = !w_rempty;
  assign out_coc        = out_valid ? w_head.coc : '0;
  assign out_res        = out_valid ? w_head.res : '0;
  assign out_div0       = out_valid && w_head.div0;
  assign busy           = r_out != '0 || out_valid;
  assign err_unexpected = r_err;
endmodule

// File: tb/tb_divisor_issuer.sv
// tb_divisor_issuer: directed vector table plus hand-written flow-control sequences.
module tb_divisor_issuer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_num = 8'd0;
  logic [7:0] in_den = 8'd0;
  logic       div_start;
  logic [7:0] div_num;
  logic [7:0] div_den;
  logic       div_done;
  logic [7:0] div_coc;
  logic [7:0] div_res;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_coc;
  logic [7:0] out_res;
  logic       out_div0;
  logic       busy;
  logic       err_unexpected;
  logic       m_done = 1'b0;
  logic [7:0] m_coc = 8'd0;
  logic [7:0] m_res = 8'd0;
  logic       auto_div = 1'b0;
  logic       mon_en = 1'b0;
  logic [1:0] f_v;
  logic [7:0] f_coc [2];
  logic [7:0] f_res [2];
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int pops = 0;
  typedef struct {
    logic [7:0] coc;
    logic [7:0] res;
    logic       div0;
  } res_t;
  typedef struct {
    logic [7:0] num;
    logic [7:0] den;
    logic [7:0] coc;
    logic [7:0] res;
    logic [7:0] ecoc;
    logic [7:0] eres;
    logic       ediv0;
  } vec_t;
  res_t q[$];
  res_t m_exp;
  res_t m_got;
  vec_t tv [6];
  logic [7:0] sp_num [6];
  logic [7:0] sp_den [6];

  divisor_issuer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .div_start(div_start),
    .div_num(div_num), .div_den(div_den), .div_done(div_done),
    .div_coc(div_coc), .div_res(div_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_coc(out_coc), .out_res(out_res),
    .out_div0(out_div0), .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  // behavioural divider with fixed two-cycle latency, used for streaming tests
  always @(posedge clk) begin
    if (rst) f_v <= 2'b00;
    else begin
      f_v      <= {f_v[0], div_start};
      f_coc[0] <= (div_den == 8'd0) ? 8'hA5 : div_num / div_den;
      f_res[0] <= (div_den == 8'd0) ? 8'h5A : div_num % div_den;
      f_coc[1] <= f_coc[0];
      f_res[1] <= f_res[0];
    end
  end
  assign div_done = auto_div ? f_v[1]   : m_done;
  assign div_coc  = auto_div ? f_coc[1] : m_coc;
  assign div_res  = auto_div ? f_res[1] : m_res;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string t);
    chk({t, "_div_start"}, div_start, 0);
    chk({t, "_div_num"}, div_num, 0);
    chk({t, "_div_den"}, div_den, 0);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_out_coc"}, out_coc, 0);
    chk({t, "_out_res"}, out_res, 0);
    chk({t, "_out_div0"}, out_div0, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_err"}, err_unexpected, 0);
  endtask

  // in-order scoreboard for the streaming phase
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (in_valid && in_ready) begin
        if (in_den == 8'd0) begin
          m_exp.coc = 8'hFF; m_exp.res = 8'h00; m_exp.div0 = 1'b1;
        end else begin
          m_exp.coc = in_num / in_den; m_exp.res = in_num % in_den; m_exp.div0 = 1'b0;
        end
        q.push_back(m_exp);
      end
      if (div_start) starts++;
      if (out_valid && out_ready) begin
        pops++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra_result got %0h/%0h expected none", out_coc, out_res);
        end else begin
          m_got = q.pop_front();
          chk("stream_coc", out_coc, m_got.coc);
          chk("stream_res", out_res, m_got.res);
          chk("stream_div0", out_div0, m_got.div0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dut.w_rpush && dut.w_rfull) begin
      errors++;
      $display("FAIL result_fifo_overflow push while full at %0t", $time);
    end
    assert (rst || !(dut.w_rpush && dut.w_rfull));
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] dc [4];
    logic [7:0] dr [4];
    logic rdy;
    int idx;
    tv[0] = '{8'd100, 8'd7, 8'd14,  8'd2,  8'd14,  8'd2, 1'b0};
    tv[1] = '{8'd55,  8'd0, 8'hAB,  8'hCD, 8'd255, 8'd0, 1'b1};
    tv[2] = '{8'd200, 8'd3, 8'd66,  8'd2,  8'd66,  8'd2, 1'b0};
    tv[3] = '{8'd7,   8'd9, 8'd0,   8'd7,  8'd0,   8'd7, 1'b0};
    tv[4] = '{8'd255, 8'd1, 8'd255, 8'd0,  8'd255, 8'd0, 1'b0};
    tv[5] = '{8'd0,   8'd0, 8'h12,  8'h34, 8'd255, 8'd0, 1'b1};
    sp_num = '{8'd100, 8'd50, 8'd9, 8'd255, 8'd1, 8'd77};
    sp_den = '{8'd7,   8'd0,  8'd2, 8'd16,  8'd1, 8'd8};
    dc = '{8'd5, 8'd6, 8'd6, 8'd10};
    dr = '{8'd0, 8'd0, 8'd4, 8'd0};

    tick;
    chk("rst_in_ready", in_ready, 0);
    check_all_zero("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_num = tv[i].num; in_den = tv[i].den;
      chk("vec_in_ready", in_ready, 1);
      tick;
      in_valid = 1'b0;
      chk("vec_start", div_start, 1);
      chk("vec_div_num", div_num, tv[i].num);
      chk("vec_div_den", div_den, tv[i].den);
      chk("vec_busy_issued", busy, 1);
      chk("vec_no_bypass", out_valid, 0);
      m_done = 1'b1; m_coc = tv[i].coc; m_res = tv[i].res;
      tick;
      m_done = 1'b0; m_coc = 8'hEE; m_res = 8'hEE;
      chk("vec_start_one_cycle", div_start, 0);
      chk("vec_num_hold", div_num, tv[i].num);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_out_coc", out_coc, tv[i].ecoc);
      chk("vec_out_res", out_res, tv[i].eres);
      chk("vec_out_div0", out_div0, tv[i].ediv0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("vec_popped", out_valid, 0);
      chk("vec_idle", busy, 0);
    end

    // simultaneous accept, DONE and pop with one credit left
    in_valid = 1'b1; in_num = 8'd10; in_den = 8'd3; tick;
    in_num = 8'd20; in_den = 8'd4; tick;
    in_num = 8'd30; in_den = 8'd5; tick;
    in_valid = 1'b0; m_done = 1'b1; m_coc = 8'd3; m_res = 8'd1; tick;
    m_done = 1'b0;
    chk("sim_pre_ready", in_ready, 1);
    chk("sim_pre_head", out_coc, 3);
    in_valid = 1'b1; in_num = 8'd40; in_den = 8'd6;
    m_done = 1'b1; m_coc = 8'd5; m_res = 8'd0; out_ready = 1'b1;
    tick;
    in_valid = 1'b0; m_done = 1'b0; out_ready = 1'b0;
    chk("sim_ready_kept", in_ready, 1);
    chk("sim_out_valid", out_valid, 1);
    chk("sim_head_coc", out_coc, 5);
    chk("sim_start", div_start, 1);
    chk("sim_div_num", div_num, 40);
    in_valid = 1'b1; in_num = 8'd50; in_den = 8'd5; tick;
    in_valid = 1'b0;
    chk("sim_credits_exhausted", in_ready, 0);
    m_done = 1'b1; m_coc = 8'd6; m_res = 8'd0; tick;
    m_coc = 8'd6; m_res = 8'd4; tick;
    m_coc = 8'd10; m_res = 8'd0; tick;
    m_done = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("sim_drain_valid", out_valid, 1);
      chk("sim_drain_coc", out_coc, dc[j]);
      chk("sim_drain_res", out_res, dr[j]);
      tick;
    end
    out_ready = 1'b0;
    chk("sim_drained", out_valid, 0);
    chk("sim_idle", busy, 0);

    // spurious DONE with nothing outstanding
    m_done = 1'b1; m_coc = 8'd1; m_res = 8'd1; tick;
    m_done = 1'b0;
    chk("spur_no_valid", out_valid, 0);
    chk("spur_err", err_unexpected, 1);
    chk("spur_busy", busy, 0);
    repeat (3) tick;
    chk("spur_err_held", err_unexpected, 1);

    // reset with two outstanding and one buffered
    in_valid = 1'b1; in_num = 8'd90; in_den = 8'd9; tick;
    in_num = 8'd80; in_den = 8'd8; tick;
    in_num = 8'd70; in_den = 8'd7; tick;
    in_valid = 1'b0; m_done = 1'b1; m_coc = 8'd10; m_res = 8'd0; tick;
    m_done = 1'b0;
    chk("prerst_valid", out_valid, 1);
    chk("prerst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_in_ready", in_ready, 0);
    tick;
    chk("rst2_in_ready", in_ready, 0);
    check_all_zero("rst2");
    rst = 1'b0;
    #1;
    chk("rst2_release_ready", in_ready, 1);
    m_done = 1'b1; tick;
    m_done = 1'b0;
    chk("stale_done_no_valid", out_valid, 0);
    chk("stale_done_err", err_unexpected, 1);
    repeat (3) tick;

    // streaming with backpressure against the behavioural divider
    auto_div = 1'b1; mon_en = 1'b1; starts = 0; pops = 0; idx = 0;
    in_valid = 1'b1; in_num = sp_num[0]; in_den = sp_den[0];
    for (int c = 0; c < 15; c++) begin
      rdy = in_ready;
      tick;
      if (rdy && idx < 6) begin
        idx++;
        if (idx < 6) begin in_num = sp_num[idx]; in_den = sp_den[idx]; end
        else in_valid = 1'b0;
      end
      if (c < 4) chk("b2b_start", div_start, 1);
    end
    chk("bp_accepts", idx, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_starts", starts, 4);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && !(idx == 6 && pops == 6); c++) begin
      rdy = in_ready;
      tick;
      if (rdy && in_valid && idx < 6) begin
        idx++;
        if (idx < 6) begin in_num = sp_num[idx]; in_den = sp_den[idx]; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("drain_accepts", idx, 6);
    chk("drain_pops", pops, 6);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_idle", busy, 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
